// File: rtl/pwm_servo_bank.sv
// pwm_servo_bank: eight-channel servo PWM with shadowed period/duty registers; optional slew limiting when PWM_SERVO_SLEW_EN is defined
module pwm_servo_bank #(
    parameter int PERIOD_RST = 1000000,
    parameter int DUTY_RST   = 75000,
    parameter int SLEW_STEP  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  addr,
    input  logic        wr,
    input  logic        rd,
    output logic [31:0] data_out,
    output logic        pwm0,
    output logic        pwm1,
    output logic        pwm2,
    output logic        pwm3,
    output logic        pwm4,
    output logic        pwm5,
    output logic        pwm6,
    output logic        pwm7
);
    localparam logic [19:0] PR = 20'(PERIOD_RST);
    localparam logic [19:0] DR = 20'(DUTY_RST);
    logic        wr_q;
    logic        enable;
    logic [7:0]  mask;
    logic [19:0] period_sh;
    logic [19:0] period_act;
    logic [19:0] cnt;
    logic [19:0] duty_sh  [8];
    logic [19:0] duty_act [8];
    logic [19:0] duty_nxt [8];
    logic        pending;
    logic [15:0] wrap_cnt;
    logic [7:0]  pwm;
    logic [31:0] rdata;
    logic [2:0]  idx;
    logic        we;
    logic        wrap;
    logic        shadow_we;
    logic        settled;
    assign we        = wr & ~wr_q;
    assign wrap      = enable && (cnt == period_act - 20'd1);
    assign idx       = 3'(addr - 8'd2);
    assign shadow_we = we && addr >= 8'd1 && addr <= 8'd9;
`ifdef PWM_SERVO_SLEW_EN
    localparam logic [19:0] STEP = 20'(SLEW_STEP);
    logic [7:0] eq;
    logic       unused_bits;
    assign unused_bits = ^data_in[31:20];
    // step each active duty toward its shadow by at most STEP, never overshooting
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            duty_nxt[i] = duty_sh[i] > duty_act[i]
                ? (duty_sh[i] - duty_act[i] > STEP ? duty_act[i] + STEP : duty_sh[i])
                : (duty_act[i] - duty_sh[i] > STEP ? duty_act[i] - STEP : duty_sh[i]);
            eq[i] = duty_nxt[i] == duty_sh[i];
        end
    end
    assign settled = &eq;
`else
    logic unused_bits;
    assign unused_bits = ^{data_in[31:20], 32'(SLEW_STEP)};
    assign duty_nxt = duty_sh;
    assign settled  = 1'b1;
`endif
    // register writes on the rising edge of wr, plus the update-pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b1;
            enable    <= 1'b0;
            mask      <= 8'hFF;
            period_sh <= PR;
            pending   <= 1'b0;
            for (int i = 0; i < 8; i++) duty_sh[i] <= DR;
        end else begin
            wr_q    <= wr;
            pending <= shadow_we ? 1'b1 : (wrap && settled) ? 1'b0 : pending;
            if (we) begin
                if (addr == 8'd0) begin
                    enable <= data_in[0];
                    mask   <= data_in[15:8];
                end else if (addr == 8'd1) begin
                    period_sh <= data_in[19:0] < 20'd2 ? 20'd2 : data_in[19:0];
                end else if (addr >= 8'd2 && addr <= 8'd9) begin
                    duty_sh[idx] <= data_in[19:0];
                end
            end
        end
    end
    // period counter; actives track shadows while disabled and reload at each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            period_act <= PR;
            wrap_cnt   <= '0;
            for (int i = 0; i < 8; i++) duty_act[i] <= DR;
        end else if (!enable) begin
            cnt        <= '0;
            period_act <= period_sh;
            for (int i = 0; i < 8; i++) duty_act[i] <= duty_sh[i];
        end else if (wrap) begin
            cnt        <= '0;
            period_act <= period_sh;
            wrap_cnt   <= wrap_cnt + 16'd1;
            for (int i = 0; i < 8; i++) duty_act[i] <= duty_nxt[i];
        end else begin
            cnt <= cnt + 20'd1;
        end
    end
    // read mux: zero-extended register at addr, zero for unmapped
    always_comb begin
        rdata = '0;
        if (addr == 8'd0) rdata = {16'b0, mask, 7'b0, enable};
        else if (addr == 8'd1) rdata = {12'b0, period_sh};
        else if (addr >= 8'd2 && addr <= 8'd9) rdata = {12'b0, duty_sh[idx]};
        else if (addr == 8'd10) rdata = {8'b0, wrap_cnt, 7'b0, pending};
    end
    // registered read data, held while rd is low
    always_ff @(posedge clk) begin
        if (rst) data_out <= '0;
        else if (rd) data_out <= rdata;
    end
    // registered PWM compare, one cycle behind the counter
    always_ff @(posedge clk) begin
        if (rst) pwm <= '0;
        else for (int i = 0; i < 8; i++) pwm[i] <= enable & mask[i] & (cnt < duty_act[i]);
    end
    assign {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0} = pwm;
endmodule

// File: tb/tb_pwm_servo_bank.sv
// tb_pwm_servo_bank: directed self-checking bench for pwm_servo_bank
module tb_pwm_servo_bank;
    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] data_out;
    logic        pwm0, pwm1, pwm2, pwm3, pwm4, pwm5, pwm6, pwm7;
    logic [7:0]  pw;
    int          total = 0;
    int          bad = 0;
    int          hi [8];

    assign pw = {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0};

    pwm_servo_bank #(.SLEW_STEP(10)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .addr(addr), .wr(wr), .rd(rd),
        .data_out(data_out),
        .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3),
        .pwm4(pwm4), .pwm5(pwm5), .pwm6(pwm6), .pwm7(pwm7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk(tag, data_out, exp);
    endtask

    task automatic measure(input int n);
        for (int k = 0; k < 8; k++) hi[k] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) hi[k] += int'(pw[k]);
        end
    endtask

    // returns at the negedge where the counter reads 1 (pwm0 just rose)
    task automatic sync0();
        logic p;
        bit   seen;
        seen = 0;
        p = pwm0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (pwm0 && !p) seen = 1;
            p = pwm0;
        end
        chk("sync_pwm0_rise", 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b1; rd = 1'b0; addr = 8'd1; data_in = 32'd5;
        tick(3);
        chk("reset_pwm", 32'(pw), 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        rst = 1'b0;
        tick(3);
        wr = 1'b0;
        rd_chk("wr_held_through_reset_period", 8'd1, 32'd1000000);
        rd_chk("reset_ctrl", 8'd0, 32'h0000FF00);
        rd_chk("reset_duty0", 8'd2, 32'd75000);
        rd_chk("reset_status", 8'd10, 32'd0);
        wr_reg(8'd1, 32'd100);
        wr_reg(8'd2, 32'd25);
        wr_reg(8'd4, 32'd20);
        wr_reg(8'd5, 32'd0);
        wr_reg(8'd6, 32'd200);
        rd_chk("status_pending_after_writes", 8'd10, 32'd1);
        rd_chk("period_readback", 8'd1, 32'd100);
        @(negedge clk);
        addr = 8'd0;
        tick(2);
        chk("data_out_held_rd_low", data_out, 32'd100);
        wr_reg(8'd0, 32'h0000FF01);
        tick(5);
        measure(300);
        chk("pwm0_duty25_x3", 32'(hi[0]), 32'd75);
        chk("pwm1_duty_rst_high", 32'(hi[1]), 32'd300);
        chk("pwm3_duty0_low", 32'(hi[3]), 32'd0);
        chk("pwm4_duty200_high", 32'(hi[4]), 32'd300);
        @(negedge clk);
        addr = 8'd3; data_in = 32'd40; wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            data_in = 32'd41 + 32'(i);
        end
        @(negedge clk);
        wr = 1'b0;
        rd_chk("wr_hold_single_write", 8'd3, 32'd40);
        sync0();
        tick(9);
        addr = 8'd4; data_in = 32'd60; wr = 1'b1;
        for (int k = 0; k < 8; k++) hi[k] = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            wr = 1'b0;
            hi[2] += int'(pwm2);
        end
        chk("pwm2_old_duty_before_wrap", 32'(hi[2]), 32'd10);
        @(negedge clk);
        addr = 8'd10; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("status_pending_before_wrap", data_out & 32'd1, 32'd1);
        tick(10);
        measure(100);
        chk("pwm2_new_duty_after_wrap", 32'(hi[2]), 32'd60);
        @(negedge clk);
        addr = 8'd10; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("status_clear_after_wrap", data_out & 32'd1, 32'd0);
        wr_reg(8'd0, 32'h00000101);
        tick(2);
        measure(100);
        chk("mask_pwm0_active", 32'(hi[0]), 32'd25);
        chk("mask_pwm4_off", 32'(hi[4]), 32'd0);
        wr_reg(8'd0, 32'h0000FF01);
        sync0();
        tick(49);
        chk("pwm4_high_before_rst", 32'(pwm4), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("pwm_low_after_rst", 32'(pw), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_period", 8'd1, 32'd1000000);
        rd_chk("rst_duty4", 8'd6, 32'd75000);
        rd_chk("rst_ctrl", 8'd0, 32'h0000FF00);
        rd_chk("rst_status", 8'd10, 32'd0);
        wr_reg(8'd1, 32'd0);
        rd_chk("period_min_clamp", 8'd1, 32'd2);
        wr_reg(8'd1, 32'hABC00064);
        rd_chk("period_upper_bits_ignored", 8'd1, 32'd100);
        rd_chk("unmapped_read_zero", 8'd32, 32'd0);
`ifdef PWM_SERVO_SLEW_EN
        wr_reg(8'd2, 32'd20);
        wr_reg(8'd0, 32'h0000FF01);
        sync0();
        wr_reg(8'd2, 32'd55);
        tick(97);
        measure(100);
        chk("slew_width_1", 32'(hi[0]), 32'd30);
        measure(100);
        chk("slew_width_2", 32'(hi[0]), 32'd40);
        measure(100);
        chk("slew_width_3", 32'(hi[0]), 32'd50);
        measure(100);
        chk("slew_width_4", 32'(hi[0]), 32'd55);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_servo_bank.md
PWM_SERVO_BANK -- requirements
Module: pwm_servo_bank

Interface
REQ-001 Parameter PERIOD_RST, default 1000000: reset PWM period in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter DUTY_RST, default 75000: reset duty of every channel in clk cycles (1.5 ms, servo centre).
REQ-003 Parameter SLEW_STEP, default 500: maximum duty change per period; used only when slew is compiled in.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 data_in  input  32  write data for the addressed register.
REQ-007 addr  input  8  register index.
REQ-008 wr  input  1  write strobe, level; a write fires on its 0->1 transition.
REQ-009 rd  input  1  read enable, level.
REQ-010 data_out  output  32  read data.
REQ-011 pwm0..pwm7  output  1 each  servo PWM outputs.

Function
REQ-012 Register map: 0x00 CTRL (bit0 ENABLE, bits 15:8 per-channel mask); 0x01 PERIOD[19:0]; 0x02-0x09 DUTY ch0-7 [19:0], shadow copy; 0x0A STATUS (bit0 UPDATE_PENDING, bits 23:8 wrap count mod 2^16), read-only.
REQ-013 A write shall occur in the cycle after wr is sampled at 0 and then at 1; holding wr high shall not repeat the write.
REQ-014 Unused data_in bits, and writes to 0x0A or unmapped addresses, shall be ignored.
REQ-015 data_out shall be registered: one cycle after rd=1 it shall hold the register at addr (zero-extended; shadow value for DUTY; 0 for unmapped); while rd=0 it shall hold its last value.
REQ-016 A 20-bit counter CNT shall count 0..PERIOD_ACT-1 and then wrap to 0; it shall run only while ENABLE=1 and shall be forced to 0 while ENABLE=0.
REQ-017 A PERIOD write below 2 shall be stored as 2.
REQ-018 Writes to PERIOD and DUTY shall update only the shadow registers and set UPDATE_PENDING.
REQ-019 On the wrap cycle (CNT=PERIOD_ACT-1, enabled), PERIOD_ACT and every DUTY_ACT shall load from the shadows and UPDATE_PENDING shall clear.
REQ-020 While ENABLE=0, shadows shall copy into the active registers every cycle.
REQ-021 A write that coincides with the wrap cycle shall land in the shadow and take effect at the next wrap; UPDATE_PENDING shall remain set.
REQ-022 pwmN shall be registered and equal ENABLE & maskN & (CNT < DUTY_ACT_N): one cycle of latency from CNT.
REQ-023 DUTY_ACT=0 shall give a constant-low output; DUTY_ACT>=PERIOD_ACT shall give a constant-high output with no glitch at wrap.
REQ-024 The wrap counter shall increment on each wrap and wrap mod 2^16.

Reset
REQ-025 On rst: CNT=0; ENABLE=0; mask=0xFF; PERIOD shadow and active = PERIOD_RST; all DUTY = DUTY_RST; UPDATE_PENDING=0; wrap count=0; data_out=0; pwm0..7=0; the wr edge-detect register=1, so a wr held high through reset does not write.
REQ-026 rst asserted mid-period shall abort the period; outputs shall be low in the cycle after rst is sampled.

Configuration
REQ-027 Macro PWM_SERVO_SLEW_EN: when defined, each DUTY_ACT at wrap shall move toward its shadow by at most SLEW_STEP (saturating, never overshooting), and UPDATE_PENDING shall stay set until every active register equals its shadow.
REQ-028 Without PWM_SERVO_SLEW_EN, DUTY_ACT shall load the shadow in full at wrap and no slew logic shall be synthesised.

Verification
REQ-029 Reset, then write CTRL=0xFF01, PERIOD=100, DUTY0=25 -> pwm0 high for 25 of 100 cycles from the first wrap onward; other channels follow DUTY_RST>=100, i.e. constant high.
REQ-030 Hold wr=1 for 10 cycles with DUTY1=40 and data_in changing -> exactly one write; DUTY1 readback = 40.
REQ-031 Write DUTY2=60 at CNT=10 of a 100-cycle period with DUTY2_ACT=20 -> 20-cycle pulse until the wrap, 60 after; STATUS bit0 = 1 until the wrap, then 0.
REQ-032 DUTY3=0 and DUTY4=200 with PERIOD=100 -> pwm3 constant 0, pwm4 constant 1 across 3 periods; PERIOD write 0 reads back 2.
REQ-033 Assert rst at CNT=50 -> all pwm outputs 0 the next cycle; registers read back at their reset values.
REQ-034 With PWM_SERVO_SLEW_EN, SLEW_STEP=10, DUTY0 changed from 20 to 55 -> pulse widths 30, 40, 50, 55 on successive periods.
